// File: rtl/regfile_pkg.sv
// Shared register-file definitions: widths, the zero register, write-back
// request record and requester indices used by the write-back path.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int SRC_ALU    = 0;
  localparam int SRC_LOAD   = 1;
  localparam int SRC_MULDIV = 2;
  localparam int SRC_LINK   = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // One-hot register decode; r0 is hardwired so its bit never reports pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] m;
    m    = {{(NUM_REGS-1){1'b0}}, 1'b1} << a;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/wb_rr_pick2.sv
// Two-grant round-robin picker: scans eligible sources from rr_ptr and picks
// the first two, skipping any candidate that targets grant A's register.
module wb_rr_pick2 #(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 5,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0]        eligible,
  input  logic [NUM_SRC*ADDR_W-1:0] addr,
  input  logic [PTR_W-1:0]          rr_ptr,
  output logic                      gnt_a_valid,
  output logic [PTR_W-1:0]          gnt_a_idx,
  output logic                      gnt_b_valid,
  output logic [PTR_W-1:0]          gnt_b_idx
);

  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] cand_addr;
  int                j;

  always_comb begin
    gnt_a_valid = 1'b0;
    gnt_a_idx   = '0;
    gnt_b_valid = 1'b0;
    gnt_b_idx   = '0;
    a_addr      = '0;
    cand_addr   = '0;
    j           = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      cand_addr = addr[j*ADDR_W +: ADDR_W];
      if (eligible[j]) begin
        if (!gnt_a_valid) begin
          gnt_a_valid = 1'b1;
          gnt_a_idx   = PTR_W'(j);
          a_addr      = cand_addr;
        end else if (!gnt_b_valid && (cand_addr != a_addr)) begin
          // Same-register candidates stay buffered so one cycle never carries two writes to one register.
          gnt_b_valid = 1'b1;
          gnt_b_idx   = PTR_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: one holding buffer per requester, up to two
// round-robin grants per cycle onto register-file ports c and d.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] req_addr,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic [ADDR_W-1:0]         write_addr_c,
  output logic                      write_enable_c,
  output logic [DATA_W-1:0]         write_data_c,
  output logic [ADDR_W-1:0]         write_addr_d,
  output logic                      write_enable_d,
  output logic [DATA_W-1:0]         write_data_d,
  output logic [31:0]               pend_mask,
  output logic                      busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        buf_valid;
  logic [ADDR_W-1:0]         buf_addr [NUM_SRC];
  logic [DATA_W-1:0]         buf_data [NUM_SRC];
  logic [PTR_W-1:0]          rr_ptr;

  logic [NUM_SRC-1:0]        eligible;
  logic [NUM_SRC-1:0]        zero_hit;
  logic [NUM_SRC-1:0]        granted;
  logic [NUM_SRC-1:0]        accept;
  logic [NUM_SRC*ADDR_W-1:0] buf_addr_flat;

  logic                      gnt_a_valid;
  logic                      gnt_b_valid;
  logic [PTR_W-1:0]          gnt_a_idx;
  logic [PTR_W-1:0]          gnt_b_idx;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_SRC - 1) ? '0 : p + 1'b1;
  endfunction

  // Buffer classification; zero-register writes retire without a port.
  always_comb begin
    eligible      = '0;
    zero_hit      = '0;
    buf_addr_flat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      buf_addr_flat[i*ADDR_W +: ADDR_W] = buf_addr[i];
      eligible[i] = buf_valid[i] && (buf_addr[i] != ADDR_W'(REG_ZERO));
      zero_hit[i] = buf_valid[i] && (buf_addr[i] == ADDR_W'(REG_ZERO));
    end
  end

  wb_rr_pick2 #(
    .NUM_SRC (NUM_SRC),
    .ADDR_W  (ADDR_W),
    .PTR_W   (PTR_W)
  ) u_pick (
    .eligible    (eligible),
    .addr        (buf_addr_flat),
    .rr_ptr      (rr_ptr),
    .gnt_a_valid (gnt_a_valid),
    .gnt_a_idx   (gnt_a_idx),
    .gnt_b_valid (gnt_b_valid),
    .gnt_b_idx   (gnt_b_idx)
  );

  // Handshake: a source transfers on req_valid && req_ready at the rising edge.
  // req_ready means the buffer is empty or is leaving this cycle (granted or
  // zero-register retire), so a source may stream back to back. req_valid must
  // not depend on req_ready; ready is forced low while reset_n is low.
  always_comb begin
    granted   = '0;
    req_ready = '0;
    accept    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      granted[i]   = (gnt_a_valid && (gnt_a_idx == PTR_W'(i))) ||
                     (gnt_b_valid && (gnt_b_idx == PTR_W'(i)));
      req_ready[i] = reset_n && (!buf_valid[i] || granted[i] || zero_hit[i]);
      accept[i]    = req_valid[i] && req_ready[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid      <= '0;
      rr_ptr         <= '0;
      write_enable_c <= 1'b0;
      write_addr_c   <= '0;
      write_data_c   <= '0;
      write_enable_d <= 1'b0;
      write_addr_d   <= '0;
      write_data_d   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        buf_addr[i] <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) begin
          buf_valid[i] <= 1'b1;
          buf_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
          buf_data[i]  <= req_data[i*DATA_W +: DATA_W];
        end else if (granted[i] || zero_hit[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end

      write_enable_c <= gnt_a_valid;
      write_addr_c   <= gnt_a_valid ? buf_addr[gnt_a_idx] : '0;
      write_data_c   <= gnt_a_valid ? buf_data[gnt_a_idx] : '0;
      write_enable_d <= gnt_b_valid;
      write_addr_d   <= gnt_b_valid ? buf_addr[gnt_b_idx] : '0;
      write_data_d   <= gnt_b_valid ? buf_data[gnt_b_idx] : '0;

      // Resume the scan just past the last source served.
      if (gnt_b_valid)      rr_ptr <= ptr_next(gnt_b_idx);
      else if (gnt_a_valid) rr_ptr <= ptr_next(gnt_a_idx);
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (buf_valid[i]) pend_mask = pend_mask | reg_onehot(REG_ADDR_W'(buf_addr[i]));
    end
    if (write_enable_c) pend_mask = pend_mask | reg_onehot(REG_ADDR_W'(write_addr_c));
    if (write_enable_d) pend_mask = pend_mask | reg_onehot(REG_ADDR_W'(write_addr_d));
  end

  assign busy = (|buf_valid) || write_enable_c || write_enable_d;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: table of request bursts with hand-derived
// issue sequences, plus hand-written reset, latency, zero-register sequences.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int RW = 1 + AW + DW + 1 + AW + DW;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   write_addr_c, write_addr_d;
  logic            write_enable_c, write_enable_d;
  logic [DW-1:0]   write_data_c, write_data_d;
  logic [31:0]     pend_mask;
  logic            busy;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.NUM_SRC(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .write_addr_c   (write_addr_c),
    .write_enable_c (write_enable_c),
    .write_data_c   (write_data_c),
    .write_addr_d   (write_addr_d),
    .write_enable_d (write_enable_d),
    .write_data_d   (write_data_d),
    .pend_mask      (pend_mask),
    .busy           (busy)
  );

  typedef struct {
    logic [N-1:0]          valid;
    logic [N-1:0][AW-1:0]  addr;
    logic [N-1:0][DW-1:0]  data;
    int                    n_exp;
    logic [2:0][RW-1:0]    exp;
  } vec_t;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_act;
  vec_t          tbl[5];
  logic [31:0]   r[12];
  logic [31:0]   d_single;
  logic [31:0]   d_async;

  function automatic logic [RW-1:0] mk(input logic ec, input logic [AW-1:0] ac, input logic [DW-1:0] dc,
                                        input logic ed, input logic [AW-1:0] ad, input logic [DW-1:0] dd);
    return {ec, ac, dc, ed, ad, dd};
  endfunction

  function automatic vec_t mkvec(input logic [N-1:0] v, input logic [N-1:0][AW-1:0] a,
                                 input logic [N-1:0][DW-1:0] d);
    vec_t t;
    t.valid = v;
    t.addr  = a;
    t.data  = d;
    t.n_exp = 0;
    t.exp   = '0;
    return t;
  endfunction

  function automatic logic [31:0] pend_of(input vec_t t);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      if (t.valid[i] && t.addr[i] != 0) m[t.addr[i]] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, busy, 0);
    chk({name, "_pend"}, pend_mask, 0);
  endtask

  // Scoreboard: every cycle with a write enable pops one expected port record.
  always @(negedge clk) begin
    if (write_enable_c === 1'b1 || write_enable_d === 1'b1) begin
      mon_act = mk(write_enable_c, write_addr_c, write_data_c, write_enable_d, write_addr_d, write_data_d);
      if (exp_q.size() == 0) chk("unexpected_write", mon_act, '0);
      else                   chk("sb_write", mon_act, exp_q.pop_front());
      if (write_enable_c && write_enable_d) chk("dual_same_addr", write_addr_c == write_addr_d, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    foreach (r[k]) r[k] = $urandom;
    d_single = 32'hDEADBEEF;
    d_async  = $urandom_range(1, 32'hFFFF);

    // Reset with all sources requesting.
    #1 reset_n = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_en_c", write_enable_c, 0);
    chk("rst_en_d", write_enable_d, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_c", write_addr_c, 0);
    req_valid = '0;
    reset_n   = 1'b1;
    #1 chk("rel_ready", req_ready, 4'hf);

    // Expected issue order derived by hand, tracking rr_ptr across vectors (starts 0).
    tbl[0] = mkvec(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {r[3], r[2], r[1], r[0]});
    tbl[0].n_exp = 2;
    tbl[0].exp[0] = mk(1, 1, r[0], 1, 2, r[1]);
    tbl[0].exp[1] = mk(1, 3, r[2], 1, 4, r[3]);
    tbl[1] = mkvec(4'b0101, {5'd0, 5'd7, 5'd0, 5'd7}, {32'd0, 32'h22, 32'd0, 32'h11});
    tbl[1].n_exp = 2;
    tbl[1].exp[0] = mk(1, 7, 32'h11, 0, 0, 0);
    tbl[1].exp[1] = mk(1, 7, 32'h22, 0, 0, 0);
    tbl[2] = mkvec(4'b1101, {5'd9, 5'd10, 5'd0, 5'd9}, {r[6], r[5], 32'd0, r[4]});
    tbl[2].n_exp = 2;
    tbl[2].exp[0] = mk(1, 9, r[6], 1, 10, r[5]);
    tbl[2].exp[1] = mk(1, 9, r[4], 0, 0, 0);
    tbl[3] = mkvec(4'b1110, {5'd31, 5'd31, 5'd31, 5'd0}, {r[9], r[8], r[7], 32'd0});
    tbl[3].n_exp = 3;
    tbl[3].exp[0] = mk(1, 31, r[7], 0, 0, 0);
    tbl[3].exp[1] = mk(1, 31, r[8], 0, 0, 0);
    tbl[3].exp[2] = mk(1, 31, r[9], 0, 0, 0);
    tbl[4] = mkvec(4'b0011, {5'd0, 5'd0, 5'd6, 5'd0}, {32'd0, 32'd0, r[11], r[10]});
    tbl[4].n_exp = 1;
    tbl[4].exp[0] = mk(1, 6, r[11], 0, 0, 0);

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_ready", v), req_ready, 4'hf);
      req_valid = tbl[v].valid;
      req_addr  = tbl[v].addr;
      req_data  = tbl[v].data;
      for (int e = 0; e < tbl[v].n_exp; e++) exp_q.push_back(tbl[v].exp[e]);
      @(negedge clk);
      req_valid = '0;
      chk($sformatf("vec%0d_pend", v), pend_mask, pend_of(tbl[v]));
      wait_idle($sformatf("vec%0d_idle", v));
      chk($sformatf("vec%0d_drain", v), exp_q.size(), 0);
    end

    // Single write: exact two-edge latency and pending bit.
    @(negedge clk);
    req_valid = 4'b0010;
    req_addr  = {5'd0, 5'd0, 5'd5, 5'd0};
    req_data  = {32'd0, 32'd0, d_single, 32'd0};
    exp_q.push_back(mk(1, 5, d_single, 0, 0, 0));
    @(negedge clk);
    req_valid = '0;
    chk("single_pend", pend_mask, 32'h20);
    chk("single_no_early_en", write_enable_c, 0);
    @(negedge clk);
    chk("single_en_c", write_enable_c, 1);
    chk("single_addr_c", write_addr_c, 5);
    chk("single_data_c", write_data_c, 32'hDEADBEEF);
    chk("single_en_d", write_enable_d, 0);
    chk("single_pend_port", pend_mask, 32'h20);
    @(negedge clk);
    chk("single_en_drop", write_enable_c, 0);
    chk("single_pend_clr", pend_mask, 0);

    // Zero register: retires silently and frees the buffer.
    @(negedge clk);
    req_valid = 4'b1000;
    req_addr  = {5'd0, 5'd0, 5'd0, 5'd0};
    req_data  = {32'hFFFF_FFFF, 96'd0};
    @(negedge clk);
    req_valid = '0;
    chk("zero_ready", req_ready[3], 1);
    chk("zero_pend", pend_mask, 0);
    @(negedge clk);
    chk("zero_busy", busy, 0);
    chk("zero_pend_after", pend_mask, 0);
    repeat (2) @(negedge clk);

    // Async reset with three buffers occupied and port c active.
    @(negedge clk);
    req_valid = 4'b0001;
    req_addr  = {5'd14, 5'd13, 5'd12, 5'd11};
    req_data  = {r[3], r[2], r[1], d_async};
    exp_q.push_back(mk(1, 11, d_async, 0, 0, 0));
    @(negedge clk);
    req_valid = 4'b1110;
    @(negedge clk);
    req_valid = '0;
    chk("async_pre_en_c", write_enable_c, 1);
    chk("async_pre_pend", pend_mask, 32'h7800);
    #2 reset_n = 1'b0;
    #1;
    chk("async_en_c", write_enable_c, 0);
    chk("async_en_d", write_enable_d, 0);
    chk("async_pend", pend_mask, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", req_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("async_post_busy", busy, 0);
    chk("async_post_pend", pend_mask, 0);
    chk("final_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
